av_wb_arbiter: RTL and testbench
================================

AV_WB_ARBITER -- requirements
Module: av_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AW, 32, address width.
- DW, 64, data width.
- MAX_OUTSTANDING, 2, maximum issued-but-unacknowledged Wishbone transfers (power of two, 2..8).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- avN_chipselect, avN_read, avN_write  in  1 each  Avalon-MM requester N command (N = 0, 1).
- avN_address  in  AW  requester N address.
- avN_writedata  in  DW  requester N write data.
- avN_byteenable  in  DW/8  requester N byte enables.
- avN_waitrequest  out  1  requester N stall.
- avN_readdata  out  DW  requester N read data.
- avN_readdatavalid  out  1  requester N read response strobe.
- wb_cyc, wb_stb, wb_we  out  1 each  pipelined Wishbone master controls.
- wb_adr  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel  out  DW/8  Wishbone byte selects.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack  in  1  Wishbone acknowledge.
- wb_stall  in  1  Wishbone stall.
- err_ack  out  1  sticky flag: acknowledge received with nothing outstanding.

Function
REQ-003 avN_valid SHALL be defined as avN_chipselect AND (avN_read OR avN_write).
REQ-004 Arbitration SHALL be round-robin using a 1-bit last_grant register.
- Both valid: grant SHALL go to the requester other than last_grant.
- One valid: grant SHALL go to that requester.
REQ-005 last_grant SHALL update only on an issue cycle, so the grant is stable while the granted requester is stalled.
REQ-006 wb_stb SHALL equal (any valid) AND (count < MAX_OUTSTANDING); the decision is combinational, with zero-cycle latency.
REQ-007 wb_adr, wb_dat_o, wb_sel, and wb_we (= write) SHALL mux from the granted requester.
- When wb_stb is low, these outputs SHALL be driven to 0.
REQ-008 Issue SHALL be defined as wb_stb AND NOT wb_stall.
- On issue, the granted requester's waitrequest SHALL be 0.
- Every other valid requester SHALL see waitrequest 1.
- Each non-valid requester's waitrequest SHALL be 0.
REQ-009 On issue, a record {requester id, we} SHALL be pushed into a MAX_OUTSTANDING-deep in-order tag FIFO.
REQ-010 On wb_ack with count > 0, the head record SHALL be popped.
- If the head is a read, the head requester's readdatavalid SHALL be 1 in the same cycle, with readdata = wb_dat_i.
- For a write, no readdatavalid SHALL be generated.
REQ-011 Non-selected readdata outputs SHALL be 0.
- readdatavalid SHALL never assert on both requesters at once.
REQ-012 count (width clog2(MAX_OUTSTANDING)+1) SHALL update as follows:
- +1 on issue only.
- -1 on valid ack only.
- Unchanged on simultaneous issue and ack.
REQ-013 At count == MAX_OUTSTANDING, wb_stb SHALL be low even if wb_ack is high in that cycle; issue resumes the next cycle.
REQ-014 wb_ack with count == 0 SHALL leave count and the FIFO unchanged and set err_ack until reset.
REQ-015 The cycle state machine SHALL have two states, IDLE and BUS.
- IDLE -> BUS on issue.
- BUS -> IDLE when count reaches 0 with no issue in that cycle.
- wb_cyc SHALL equal (state == BUS) OR wb_stb.
REQ-016 Tag FIFO read and write pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-017 On rst_n low, the following SHALL take effect asynchronously:
- state = IDLE, count = 0, last_grant = 1 (requester 0 wins the first tie).
- FIFO pointers = 0, err_ack = 0.
REQ-018 Reset mid-transfer SHALL discard all outstanding records.
- No readdatavalid SHALL be produced for pre-reset transfers.
REQ-019 All outputs SHALL be 0 during reset, except waitrequest = 0 for non-valid requesters.

Structure
REQ-020 Package av_wb_pkg SHALL hold:
- the requester-id typedef;
- the tag-record struct {id, we};
- the IDLE/BUS state enum;
- the default MAX_OUTSTANDING constant.
REQ-021 The tag FIFO SHALL be the sub-module av_wb_tag_fifo, with push, pop, head, full, empty, and clk/rst_n.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Both requesters read 0x100 and 0x200 in the same cycle after reset -> requester 0 issues first, then requester 1; acks route readdatavalid to 0 then 1, with data 0xA and 0xB.
- Requester 0 issues 3 back-to-back reads with no ack, MAX_OUTSTANDING = 2 -> the third read holds waitrequest = 1 until the first ack, then issues in the next cycle.
- A write from requester 1 is acked -> no readdatavalid on either requester; count returns to 0; wb_cyc drops one cycle later.
- wb_stall held 4 cycles with both requesters valid -> grant stays unchanged; issue occurs on the cycle stall falls.
- Spurious wb_ack while idle -> err_ack = 1 and stays 1; count stays 0.
- rst_n asserted with 2 reads outstanding, then late acks arrive after release -> no readdatavalid; err_ack = 1.

Source files
------------

// File: rtl/av_wb_pkg.sv
// Shared types for the Avalon-MM to pipelined Wishbone arbiter.
package av_wb_pkg;

  localparam int unsigned MAX_OUTSTANDING_DEF = 2;

  typedef logic req_id_t;

  typedef struct packed {
    req_id_t id;
    logic    we;
  } tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

endpackage

// File: rtl/av_wb_tag_fifo.sv
// In-order record of issued transfers, popped as Wishbone acks return.
module av_wb_tag_fifo
  import av_wb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  tag_t          mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

endmodule

// File: rtl/av_wb_arbiter.sv
// Two Avalon-MM requesters sharing one pipelined Wishbone master port,
// round-robin arbitrated, with in-order read response routing.
module av_wb_arbiter
  import av_wb_pkg::*;
#(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 64,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            av0_chipselect,
  input  logic            av0_read,
  input  logic            av0_write,
  input  logic [AW-1:0]   av0_address,
  input  logic [DW-1:0]   av0_writedata,
  input  logic [DW/8-1:0] av0_byteenable,
  output logic            av0_waitrequest,
  output logic [DW-1:0]   av0_readdata,
  output logic            av0_readdatavalid,
  input  logic            av1_chipselect,
  input  logic            av1_read,
  input  logic            av1_write,
  input  logic [AW-1:0]   av1_address,
  input  logic [DW-1:0]   av1_writedata,
  input  logic [DW/8-1:0] av1_byteenable,
  output logic            av1_waitrequest,
  output logic [DW-1:0]   av1_readdata,
  output logic            av1_readdatavalid,
  output logic            wb_cyc,
  output logic            wb_stb,
  output logic            wb_we,
  output logic [AW-1:0]   wb_adr,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack,
  input  logic            wb_stall,
  output logic            err_ack
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  req_id_t       last_grant_q, last_grant_d;
  logic          err_ack_q, err_ack_d;
  logic          run_q;

  logic    av0_valid, av1_valid, any_valid;
  req_id_t grant;
  logic    issue, ack_ok;
  tag_t    head_tag;
  logic    fifo_full, fifo_empty;

  assign av0_valid = av0_chipselect && (av0_read || av0_write);
  assign av1_valid = av1_chipselect && (av1_read || av1_write);
  assign any_valid = av0_valid || av1_valid;

  always_comb begin
    if (av0_valid && av1_valid) begin
      grant = ~last_grant_q;
    end else if (av1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // FIFO occupancy and count_q always agree; run_q keeps the bus quiet
  // while reset is held and until the first clock after its release.
  assign wb_stb = run_q && any_valid && !fifo_full;
  assign issue  = wb_stb && !wb_stall;
  assign ack_ok = wb_ack && !fifo_empty;
  assign wb_cyc = (state_q == BUS) || wb_stb;

  always_comb begin
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_dat_o = '0;
    wb_sel   = '0;
    if (wb_stb) begin
      if (grant == 1'b1) begin
        wb_we    = av1_write;
        wb_adr   = av1_address;
        wb_dat_o = av1_writedata;
        wb_sel   = av1_byteenable;
      end else begin
        wb_we    = av0_write;
        wb_adr   = av0_address;
        wb_dat_o = av0_writedata;
        wb_sel   = av0_byteenable;
      end
    end
  end

  assign av0_waitrequest = av0_valid && !(issue && (grant == 1'b0));
  assign av1_waitrequest = av1_valid && !(issue && (grant == 1'b1));

  assign av0_readdatavalid = ack_ok && !head_tag.we && (head_tag.id == 1'b0);
  assign av1_readdatavalid = ack_ok && !head_tag.we && (head_tag.id == 1'b1);
  assign av0_readdata      = av0_readdatavalid ? wb_dat_i : '0;
  assign av1_readdata      = av1_readdatavalid ? wb_dat_i : '0;
  assign err_ack           = err_ack_q;

  av_wb_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (issue),
    .push_tag('{id: grant, we: wb_we}),
    .pop     (ack_ok),
    .head    (head_tag),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    count_d      = count_q;
    state_d      = state_q;
    last_grant_d = issue ? grant : last_grant_q;
    err_ack_d    = err_ack_q || (wb_ack && (count_q == '0));
    case ({issue, ack_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE:    if (issue) state_d = BUS;
      BUS:     if (!issue && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      err_ack_q    <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      err_ack_q    <= err_ack_d;
      run_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_av_wb_arbiter.sv
// Directed, table-driven check of av_wb_arbiter with two requesters.
module tb_av_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam logic [63:0] D0 = 64'hD0D0_0000_0000_00A0;
  localparam logic [63:0] D1 = 64'hD1D1_0000_0000_00B1;
  localparam logic [7:0]  S0 = 8'h0F;
  localparam logic [7:0]  S1 = 8'hF0;

  logic clk, rst_n;
  logic av0_cs, av0_rd, av0_wr, av0_wait, av0_rdv;
  logic av1_cs, av1_rd, av1_wr, av1_wait, av1_rdv;
  logic [AW-1:0] av0_addr, av1_addr, wb_adr;
  logic [DW-1:0] av0_rdata, av1_rdata, wb_dat_o, wb_dat_i;
  logic [7:0] wb_sel;
  logic wb_cyc, wb_stb, wb_we, wb_ack, wb_stall, err_ack;

  av_wb_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .av0_chipselect(av0_cs), .av0_read(av0_rd), .av0_write(av0_wr),
    .av0_address(av0_addr), .av0_writedata(D0), .av0_byteenable(S0),
    .av0_waitrequest(av0_wait), .av0_readdata(av0_rdata), .av0_readdatavalid(av0_rdv),
    .av1_chipselect(av1_cs), .av1_read(av1_rd), .av1_write(av1_wr),
    .av1_address(av1_addr), .av1_writedata(D1), .av1_byteenable(S1),
    .av1_waitrequest(av1_wait), .av1_readdata(av1_rdata), .av1_readdatavalid(av1_rdv),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .err_ack(err_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic stb, cyc, we;
    logic [31:0] adr;
    logic [63:0] dat;
    logic [7:0] sel;
    logic w0, w1, rv0, rv1;
    logic [63:0] rd0, rd1;
    logic err;
  } obs_t;

  typedef struct packed {
    logic v0r, v0w; logic [31:0] a0;
    logic v1r, v1w; logic [31:0] a1;
    logic st, ak; logic [63:0] di;
    logic e_stb, e_cyc, e_g, e_w0, e_w1, e_rv0, e_rv1;
    logic [63:0] e_rdata;
    logic e_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs [20];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  function automatic obs_t get_obs();
    obs_t o;
    o = '{wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_o, wb_sel,
          av0_wait, av1_wait, av0_rdv, av1_rdv, av0_rdata, av1_rdata, err_ack};
    return o;
  endfunction

  function automatic obs_t exp_obs(input vec_t v);
    obs_t e;
    e.stb = v.e_stb;
    e.cyc = v.e_cyc;
    e.we  = v.e_stb ? (v.e_g ? v.v1w : v.v0w) : 1'b0;
    e.adr = v.e_stb ? (v.e_g ? v.a1 : v.a0) : 32'h0;
    e.dat = v.e_stb ? (v.e_g ? D1 : D0) : 64'h0;
    e.sel = v.e_stb ? (v.e_g ? S1 : S0) : 8'h0;
    e.w0  = v.e_w0;
    e.w1  = v.e_w1;
    e.rv0 = v.e_rv0;
    e.rv1 = v.e_rv1;
    e.rd0 = v.e_rv0 ? v.e_rdata : 64'h0;
    e.rd1 = v.e_rv1 ? v.e_rdata : 64'h0;
    e.err = v.e_err;
    return e;
  endfunction

  task automatic drive(input logic v0r, v0w, input logic [31:0] a0,
                       input logic v1r, v1w, input logic [31:0] a1,
                       input logic st, ak, input logic [63:0] di);
    av0_cs = v0r | v0w; av0_rd = v0r; av0_wr = v0w; av0_addr = a0;
    av1_cs = v1r | v1w; av1_rd = v1r; av1_wr = v1w; av1_addr = a1;
    wb_stall = st; wb_ack = ak; wb_dat_i = di;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v0r v0w a0 | v1r v1w a1 | stall ack dat_i | stb cyc g w0 w1 rv0 rv1 rdata err
    vecs[0]  = '{1,0,'h100, 1,0,'h200, 0,0,'h0,    1,1,0,0,1,0,0,'h0,   0};
    vecs[1]  = '{0,0,'h0,   1,0,'h200, 0,0,'h0,    1,1,1,0,0,0,0,'h0,   0};
    vecs[2]  = '{0,0,'h0,   0,0,'h0,   0,1,'hA,    0,1,0,0,0,1,0,'hA,   0};
    vecs[3]  = '{0,0,'h0,   0,0,'h0,   0,1,'hB,    0,1,0,0,0,0,1,'hB,   0};
    vecs[4]  = '{0,0,'h0,   0,0,'h0,   0,0,'h0,    0,0,0,0,0,0,0,'h0,   0};
    vecs[5]  = '{0,0,'h0,   0,1,'h300, 0,0,'h0,    1,1,1,0,0,0,0,'h0,   0};
    vecs[6]  = '{0,0,'h0,   0,0,'h0,   0,1,'h5555, 0,1,0,0,0,0,0,'h0,   0};
    vecs[7]  = '{0,0,'h0,   0,0,'h0,   0,0,'h0,    0,0,0,0,0,0,0,'h0,   0};
    vecs[8]  = '{1,0,'h400, 1,0,'h500, 1,0,'h0,    1,1,0,1,1,0,0,'h0,   0};
    vecs[9]  = '{1,0,'h400, 1,0,'h500, 1,0,'h0,    1,1,0,1,1,0,0,'h0,   0};
    vecs[10] = '{1,0,'h400, 1,0,'h500, 1,0,'h0,    1,1,0,1,1,0,0,'h0,   0};
    vecs[11] = '{1,0,'h400, 1,0,'h500, 1,0,'h0,    1,1,0,1,1,0,0,'h0,   0};
    vecs[12] = '{1,0,'h400, 1,0,'h500, 0,0,'h0,    1,1,0,0,1,0,0,'h0,   0};
    vecs[13] = '{0,0,'h0,   1,0,'h500, 0,0,'h0,    1,1,1,0,0,0,0,'h0,   0};
    vecs[14] = '{0,0,'h0,   0,0,'h0,   0,1,'hC,    0,1,0,0,0,1,0,'hC,   0};
    vecs[15] = '{0,0,'h0,   0,0,'h0,   0,1,'hD,    0,1,0,0,0,0,1,'hD,   0};
    vecs[16] = '{0,0,'h0,   0,0,'h0,   0,0,'h0,    0,0,0,0,0,0,0,'h0,   0};
    vecs[17] = '{0,0,'h0,   0,0,'h0,   0,1,'hEE,   0,0,0,0,0,0,0,'h0,   0};
    vecs[18] = '{0,0,'h0,   0,0,'h0,   0,0,'h0,    0,0,0,0,0,0,0,'h0,   1};
    vecs[19] = '{0,0,'h0,   0,0,'h0,   0,0,'h0,    0,0,0,0,0,0,0,'h0,   1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_outputs", 256'(get_obs()), 256'(obs_t'('0)));
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v0r, vecs[i].v0w, vecs[i].a0, vecs[i].v1r, vecs[i].v1w,
            vecs[i].a1, vecs[i].st, vecs[i].ak, vecs[i].di);
      #4;
      chk($sformatf("vec%0d", i), 256'(get_obs()), 256'(exp_obs(vecs[i])));
      step();
    end

    // Requester 0: three back-to-back reads against a two-deep limit
    drive(1, 0, 'h600, 0, 0, 0, 0, 0, 0); #4;
    chk("s2_issue1_stb", 256'(wb_stb), 256'(1)); chk("s2_issue1_wait", 256'(av0_wait), 256'(0));
    step();
    drive(1, 0, 'h608, 0, 0, 0, 0, 0, 0); #4;
    chk("s2_issue2_wait", 256'(av0_wait), 256'(0));
    step();
    drive(1, 0, 'h610, 0, 0, 0, 0, 0, 0); #4;
    chk("s2_full_stb", 256'(wb_stb), 256'(0)); chk("s2_full_wait", 256'(av0_wait), 256'(1));
    step(); #4;
    chk("s2_hold_wait", 256'(av0_wait), 256'(1));
    step();
    drive(1, 0, 'h610, 0, 0, 0, 0, 1, 64'hE); #4;
    chk("s2_ack_at_max_stb", 256'(wb_stb), 256'(0));
    chk("s2_ack_at_max_wait", 256'(av0_wait), 256'(1));
    chk("s2_ack_rdv", 256'({av0_rdv, av1_rdv, av0_rdata}), 256'({1'b1, 1'b0, 64'hE}));
    step();
    drive(1, 0, 'h610, 0, 0, 0, 0, 0, 0); #4;
    chk("s2_resume", 256'({wb_stb, av0_wait, wb_adr}), 256'({1'b1, 1'b0, 32'h610}));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 64'hF); #4;
    chk("s2_drain1", 256'({av0_rdv, av0_rdata}), 256'({1'b1, 64'hF}));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h10); #4;
    chk("s2_drain2", 256'({av0_rdv, av0_rdata}), 256'({1'b1, 64'h10}));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #4;
    chk("s2_cyc_drop", 256'(wb_cyc), 256'(0));
    step();

    // Reset with two reads outstanding, then late acks
    drive(1, 0, 'h700, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 'h708, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #4;
    chk("s6_outstanding_cyc", 256'({wb_cyc, wb_stb}), 256'({1'b1, 1'b0}));
    step();
    drive(1, 0, 'h710, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; #4;
    chk("s6_in_reset", 256'({wb_stb, wb_cyc, wb_adr, err_ack}), 256'(0));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h77); #4;
    chk("s6_late_ack1", 256'({av0_rdv, av1_rdv, av0_rdata, av1_rdata, wb_cyc}), 256'(0));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h78); #4;
    chk("s6_late_ack2", 256'({av0_rdv, av1_rdv, wb_cyc, err_ack}), 256'({3'b000, 1'b1}));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #4;
    chk("s6_err_sticky", 256'({err_ack, wb_cyc}), 256'({1'b1, 1'b0}));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
